// File: rtl/clock_freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// clock_freq_meter_pkg
// Shared types for the clock frequency meter.
//   fm_state_t : measurement FSM states
//     IDLE    - meter disabled, nothing is being counted
//     ARM     - enabled, waiting for the first rising edge to start a period
//     MEASURE - counting clk_in cycles between consecutive rising edges
//     TIMEOUT - no rising edge arrived before the period counter saturated
// ---------------------------------------------------------------------------
package clock_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    TIMEOUT
  } fm_state_t;

endpackage

// File: rtl/clock_freq_meter_edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Brings the asynchronous measured signal into the clk_in domain and flags
// its rising edges.
//   clk_in     : system clock, rising-edge
//   rst_n      : asynchronous active-low reset
//   sig_in     : asynchronous signal under measurement
//   sync_level : synchronized level of sig_in (last synchronizer stage)
//   rise       : registered one-cycle pulse, SYNC_STAGES+1 cycles after
//                sig_in rises; it lags sync_level by one cycle
// ---------------------------------------------------------------------------
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic sync_level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_prev;

  assign sync_level = sync_chain[SYNC_STAGES-1];

  // Synchronizer chain, previous-level flop and registered edge pulse.
  // Registering the pulse keeps the FSM input a clean flop output.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
      sync_prev  <= 1'b0;
      rise       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
      sync_prev  <= sync_chain[SYNC_STAGES-1];
      rise       <= sync_chain[SYNC_STAGES-1] & ~sync_prev;
    end
  end

endmodule

// File: rtl/clock_freq_meter.sv
// ---------------------------------------------------------------------------
// clock_freq_meter
// Measures the period and high time of an asynchronous clock-like signal in
// clk_in cycles and reports lock once the period has been stable.
//   clk_in    : system clock, rising-edge
//   rst_n     : asynchronous active-low reset
//   enable    : level-sensitive measurement enable
//   sig_in    : asynchronous signal under measurement
//   period    : last rising-to-rising distance in clk_in cycles
//   high_time : synchronized-high cycles within that period
//   valid     : one-cycle pulse when period/high_time update
//   locked    : last LOCK_COUNT periods identical
//   timeout   : no rising edge within 2^CNT_W-1 cycles
// ---------------------------------------------------------------------------
module clock_freq_meter
  import clock_freq_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int                 MATCH_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  fm_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   hcnt;
  logic [MATCH_W-1:0] match;
  logic [MATCH_W-1:0] match_next;
  logic               first_meas;
  logic               sync_level;
  logic               rise;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .sync_level(sync_level),
    .rise      (rise)
  );

  // Match count the next measurement would produce. The period register
  // still holds the previous measurement, so it is compared against cnt.
  // The first measurement after ARM/TIMEOUT has nothing valid to compare.
  always_comb begin
    match_next = MATCH_ONE;
    if (!first_meas && (cnt == period)) begin
      match_next = (match == MATCH_MAX) ? MATCH_MAX : match + MATCH_ONE;
    end
  end

  // Measurement FSM with counters, lock tracking and registered outputs.
  // Disable has priority over everything, including a coincident edge.
  // A rise always closes the period even when cnt has saturated, so the
  // timeout only fires when cnt is already all-ones and no edge arrives.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hcnt       <= '0;
      match      <= '0;
      first_meas <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        cnt        <= '0;
        hcnt       <= '0;
        match      <= '0;
        first_meas <= 1'b0;
        locked     <= 1'b0;
        timeout    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              state      <= MEASURE;
              cnt        <= CNT_ONE;
              hcnt       <= CNT_ONE;
              first_meas <= 1'b1;
            end
          end
          MEASURE: begin
            if (rise) begin
              period     <= cnt;
              high_time  <= hcnt;
              valid      <= 1'b1;
              cnt        <= CNT_ONE;
              hcnt       <= CNT_ONE;
              match      <= match_next;
              locked     <= (match_next == MATCH_MAX);
              first_meas <= 1'b0;
            end else if (cnt == CNT_MAX) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
              locked  <= 1'b0;
              match   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (sync_level && (hcnt != CNT_MAX)) begin
                hcnt <= hcnt + CNT_ONE;
              end
            end
          end
          TIMEOUT: begin
            if (rise) begin
              state      <= MEASURE;
              timeout    <= 1'b0;
              cnt        <= CNT_ONE;
              hcnt       <= CNT_ONE;
              first_meas <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
